button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter NUM_BTN, default 3, number of button channels (1..16).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable synchronized samples required to accept a level change (>=1).
REQ-003 SHALL have parameter REPEAT_DELAY, default 8, cycles a button is held after its press pulse before the first repeat (>=1).
REQ-004 SHALL have parameter REPEAT_PERIOD, default 4, cycles between subsequent repeats (>=1).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, event queue entries (power of two, >=2).
REQ-006 SHALL have parameter ACTIVE_LOW, default 1; when 1, raw input 0 means pressed.
REQ-007 SHALL have port clk  input  1  the single clock, all logic on rising edge.
REQ-008 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-009 SHALL have port btn_raw  input  NUM_BTN  asynchronous raw button levels.
REQ-010 SHALL have port enable  input  1  turn lock: 0 suppresses event generation.
REQ-011 SHALL have port btn_level  output  NUM_BTN  debounced pressed state, 1 = pressed.
REQ-012 SHALL have port btn_press  output  NUM_BTN  one-cycle pulse on accepted press.
REQ-013 SHALL have port btn_release  output  NUM_BTN  one-cycle pulse on accepted release.
REQ-014 SHALL have port evt_valid  output  1  event queue not empty.
REQ-015 SHALL have port evt_code  output  $clog2(NUM_BTN)+1  head event: {repeat_flag, button index}.
REQ-016 SHALL have port evt_ready  input  1  consumer pops head when evt_valid && evt_ready.
REQ-017 SHALL have port evt_drop  output  1  one-cycle pulse when an event is lost.

Function
REQ-018 Each btn_raw bit SHALL pass a 2-flop synchronizer, then be inverted when ACTIVE_LOW=1.
REQ-019 Per-channel FSM SHALL have states IDLE, PRESS_DB, HELD, RELEASE_DB.
REQ-020 IDLE->PRESS_DB when the synchronized sample is pressed; the counter loads 1.
REQ-021 PRESS_DB SHALL count stable pressed samples; any released sample returns to IDLE; reaching DEBOUNCE_CYCLES -> HELD, btn_level<=1, btn_press pulses that same cycle.
REQ-022 Press latency SHALL be exactly 2+DEBOUNCE_CYCLES cycles from the first clock edge that samples the new raw level.
REQ-023 HELD->RELEASE_DB on a released sample; RELEASE_DB mirrors PRESS_DB, with btn_level<=0 and a btn_release pulse on acceptance, or a return to HELD on a pressed sample.
REQ-024 In HELD, a hold counter SHALL fire a repeat REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles; the hold counter freezes in RELEASE_DB and clears on HELD entry from PRESS_DB.
REQ-025 Events: press gives code {0,idx}; repeat gives {1,idx}; releases generate no event.
REQ-026 Events SHALL be generated only when enable=1; btn_level/press/release pulses are unaffected by enable.
REQ-027 If several channels raise events in one cycle, the lowest index SHALL be enqueued and evt_drop pulses.
REQ-028 FIFO: write when an event exists and not full; event while full -> not written, evt_drop pulses.
REQ-029 Simultaneous push and pop while full SHALL accept both (count unchanged); push and pop while empty SHALL NOT pass through (evt_valid rises next cycle).
REQ-030 evt_code SHALL be stable while evt_valid && !evt_ready.
REQ-031 Pointers SHALL wrap modulo FIFO_DEPTH; the count field is $clog2(FIFO_DEPTH)+1 bits.

Reset
REQ-032 With rst=1 at a clock edge: all FSMs IDLE, counters 0, synchronizers to released level, FIFO empty.
REQ-033 During and after reset: btn_level=0, btn_press=0, btn_release=0, evt_valid=0, evt_drop=0, evt_code=0.
REQ-034 A button held through reset deassertion SHALL produce a fresh press after full debounce.

Structure
REQ-035 Package input_pkg SHALL hold the FSM state enum and the evt_code packing function.
REQ-036 Per-channel synchronizer, FSM and counters SHALL be sub-module btn_channel, generated NUM_BTN times; the arbiter and FIFO stay in the top level.

Verification (NUM_BTN=3, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4, FIFO_DEPTH=4, ACTIVE_LOW=1)
REQ-037 btn_raw[0] 1->0 held 20 cycles, enable=1 -> btn_press[0] at +6, evt_code=0b000 queued, repeats 0b100 at +14 and +18.
REQ-038 btn_raw[1] bounce: 0 for 3 cycles, then 1 -> no btn_press, no event, btn_level stays 0.
REQ-039 btn_raw[0] and btn_raw[2] pressed in the same cycle -> one event 0b000 and an evt_drop pulse, while btn_press[0] and btn_press[2] both pulse.
REQ-040 evt_ready=0 with 5 press events -> evt_valid=1, 4 entries in order, evt_drop on the 5th; then evt_ready=1 -> 4 pops, then evt_valid=0.
REQ-041 enable=0 during a press -> btn_press/btn_level toggle, evt_valid stays 0.
REQ-042 rst=1 for 1 cycle while button 0 is HELD with 2 queued events -> all outputs 0 next cycle, and a new press after 6 cycles.

Source files
------------

// File: rtl/input_pkg.sv
// Shared types for the button conditioner: per-channel FSM states and event code packing.
package input_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_DB,
        ST_HELD,
        ST_RELEASE_DB
    } btn_state_t;

    localparam int unsigned IDX_MAX_W  = 4;
    localparam int unsigned CODE_MAX_W = IDX_MAX_W + 1;

    // Event code is {repeat_flag, button index}; the flag sits just above idx_w index bits.
    function automatic logic [CODE_MAX_W-1:0] pack_evt(
        input logic                 rpt,
        input logic [IDX_MAX_W-1:0] idx,
        input int unsigned          idx_w
    );
        return CODE_MAX_W'(idx) | (CODE_MAX_W'(rpt) << idx_w);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchronizer, debounce FSM and auto-repeat hold counter.
module btn_channel
    import input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 8,
    parameter int unsigned REPEAT_PERIOD   = 4,
    parameter int unsigned ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_rpt
);

    localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic        REL_LVL  = (ACTIVE_LOW != 0);

    logic [1:0]        r_sync;
    btn_state_t        r_state;
    logic [DB_W-1:0]   r_db_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_first;
    logic              r_level;
    logic              r_press;
    logic              r_release;
    logic              r_rpt;

    logic              w_pressed;
    logic [HOLD_W-1:0] w_hold_tgt;

    assign w_pressed  = r_sync[1] ^ REL_LVL;
    assign w_hold_tgt = r_first ? HOLD_W'(REPEAT_DELAY - 1) : HOLD_W'(REPEAT_PERIOD - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync     <= {2{REL_LVL}};
            r_state    <= ST_IDLE;
            r_db_cnt   <= '0;
            r_hold_cnt <= '0;
            r_first    <= 1'b0;
            r_level    <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_rpt      <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_raw};
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_rpt     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pressed) begin
                        r_state  <= ST_PRESS_DB;
                        r_db_cnt <= DB_W'(1);
                    end
                end
                ST_PRESS_DB: begin
                    if (!w_pressed) begin
                        r_state  <= ST_IDLE;
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES)) begin
                        r_state    <= ST_HELD;
                        r_db_cnt   <= '0;
                        r_level    <= 1'b1;
                        r_press    <= 1'b1;
                        r_hold_cnt <= '0;
                        r_first    <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + DB_W'(1);
                    end
                end
                ST_HELD: begin
                    if (!w_pressed) begin
                        r_state  <= ST_RELEASE_DB;
                        r_db_cnt <= DB_W'(1);
                    end else if (r_hold_cnt == w_hold_tgt) begin
                        r_rpt      <= 1'b1;
                        r_hold_cnt <= '0;
                        r_first    <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                ST_RELEASE_DB: begin
                    // Hold counter is frozen here so a glitchy release resumes the repeat cadence.
                    if (w_pressed) begin
                        r_state  <= ST_HELD;
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES)) begin
                        r_state   <= ST_IDLE;
                        r_db_cnt  <= '0;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + DB_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_rpt     = r_rpt;

endmodule

// File: rtl/button_conditioner.sv
// Debounced multi-button front end with auto-repeat, lowest-index event arbitration and an event FIFO.
module button_conditioner
    import input_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 8,
    parameter int unsigned REPEAT_PERIOD   = 4,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned ACTIVE_LOW      = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_BTN-1:0]         btn_raw,
    input  logic                       enable,
    output logic [NUM_BTN-1:0]         btn_level,
    output logic [NUM_BTN-1:0]         btn_press,
    output logic [NUM_BTN-1:0]         btn_release,
    output logic                       evt_valid,
    output logic [$clog2(NUM_BTN):0]   evt_code,
    input  logic                       evt_ready,
    output logic                       evt_drop
);

    localparam int unsigned IDX_W  = $clog2(NUM_BTN);
    localparam int unsigned CODE_W = IDX_W + 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    logic [NUM_BTN-1:0]   w_rpt;
    logic [NUM_BTN-1:0]   w_req;
    logic [IDX_MAX_W-1:0] w_idx;
    logic                 w_rpt_sel;
    logic                 w_any;
    logic                 w_multi;
    logic [CODE_W-1:0]    w_code;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [PTR_W-1:0]     w_rd_nxt;
    logic [CODE_W-1:0]    w_head_nxt;

    logic [CODE_W-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_evt_valid;
    logic [CODE_W-1:0]    r_evt_code;
    logic                 r_evt_drop;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_raw     (btn_raw[g]),
            .o_level   (btn_level[g]),
            .o_press   (btn_press[g]),
            .o_release (btn_release[g]),
            .o_rpt     (w_rpt[g])
        );
    end

    // Lowest-index arbitration; losers are counted as dropped events.
    always_comb begin
        w_req     = enable ? (btn_press | w_rpt) : '0;
        w_any     = |w_req;
        w_multi   = |(w_req & (w_req - NUM_BTN'(1)));
        w_idx     = '0;
        w_rpt_sel = 1'b0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_idx     = IDX_MAX_W'(i);
                w_rpt_sel = w_rpt[i];
            end
        end
        w_code = CODE_W'(pack_evt(w_rpt_sel, w_idx, IDX_W));
    end

    // FIFO control; the registered head is computed from next-state so evt_code has no read mux after the flop.
    always_comb begin
        w_full     = (r_count == CNT_W'(FIFO_DEPTH));
        w_pop      = r_evt_valid & evt_ready;
        w_push     = w_any & (!w_full | w_pop);
        w_drop     = w_multi | (w_any & w_full & !w_pop);
        w_cnt_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_rd_nxt   = w_pop ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;
        w_head_nxt = r_mem[w_rd_nxt];
        if (w_cnt_nxt == '0) begin
            w_head_nxt = '0;
        end else if (w_push && (r_wr_ptr == w_rd_nxt)) begin
            w_head_nxt = w_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_evt_valid <= 1'b0;
            r_evt_code  <= '0;
            r_evt_drop  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_code;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr    <= w_rd_nxt;
            r_count     <= w_cnt_nxt;
            r_evt_valid <= (w_cnt_nxt != '0);
            r_evt_code  <= w_head_nxt;
            r_evt_drop  <= w_drop;
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_code  = r_evt_code;
    assign evt_drop  = r_evt_drop;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with an expected-event scoreboard checked at every FIFO pop.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] btn_raw;
    logic       enable;
    logic [2:0] btn_level;
    logic [2:0] btn_press;
    logic [2:0] btn_release;
    logic       evt_valid;
    logic [2:0] evt_code;
    logic       evt_ready;
    logic       evt_drop;

    int         total = 0;
    int         bad   = 0;
    int         drops = 0;
    logic [2:0] exp_q [$];
    int         d0;

    button_conditioner #(
        .NUM_BTN         (3),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (8),
        .REPEAT_PERIOD   (4),
        .FIFO_DEPTH      (4),
        .ACTIVE_LOW      (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .enable      (enable),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .evt_valid   (evt_valid),
        .evt_code    (evt_code),
        .evt_ready   (evt_ready),
        .evt_drop    (evt_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_level"},   32'(btn_level),   0);
        check({tag, "_press"},   32'(btn_press),   0);
        check({tag, "_release"}, 32'(btn_release), 0);
        check({tag, "_valid"},   32'(evt_valid),   0);
        check({tag, "_drop"},    32'(evt_drop),    0);
        check({tag, "_code"},    32'(evt_code),    0);
    endtask

    // Scoreboard: every accepted pop must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst) begin
            if (evt_drop) drops++;
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL evt_unexpected observed=%0h expected=none", evt_code);
                end else begin
                    check("evt_code", 32'(evt_code), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        btn_raw   = 3'b111;
        enable    = 1'b1;
        evt_ready = 1'b1;
        tick(2);
        check_idle_outputs("reset");
        rst = 1'b0;
        tick(3);
        check_idle_outputs("post_reset");

        // Press and hold button 0: press at +6, repeats 8 then 4 cycles later.
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b100);
        btn_raw = 3'b110;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            check($sformatf("hold_press_k%0d", k), 32'(btn_press), (k == 7) ? 1 : 0);
            check($sformatf("hold_valid_k%0d", k), 32'(evt_valid), (k == 8 || k == 16 || k == 20) ? 1 : 0);
        end
        btn_raw = 3'b111;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            check($sformatf("rel_pulse_k%0d", k), 32'(btn_release), (k == 7) ? 1 : 0);
            check($sformatf("rel_level_k%0d", k), 32'(btn_level), (k < 7) ? 1 : 0);
            check($sformatf("rel_valid_k%0d", k), 32'(evt_valid), 0);
        end

        // Bounce on button 1 shorter than the debounce window.
        btn_raw = 3'b101;
        tick(3);
        btn_raw = 3'b111;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            check("bounce_press", 32'(btn_press), 0);
            check("bounce_level", 32'(btn_level), 0);
            check("bounce_valid", 32'(evt_valid), 0);
        end

        // Buttons 0 and 2 together: one event, one drop, both press pulses.
        exp_q.push_back(3'b000);
        btn_raw = 3'b010;
        for (int k = 1; k <= 9; k++) begin
            tick(1);
            check($sformatf("dual_press_k%0d", k), 32'(btn_press), (k == 7) ? 32'h5 : 0);
            check($sformatf("dual_drop_k%0d", k), 32'(evt_drop), (k == 8) ? 1 : 0);
        end
        btn_raw = 3'b111;
        tick(12);

        // Disabled events: level/press still toggle, queue stays empty.
        enable  = 1'b0;
        btn_raw = 3'b101;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            check($sformatf("dis_press_k%0d", k), 32'(btn_press), (k == 7) ? 32'h2 : 0);
            check($sformatf("dis_level_k%0d", k), 32'(btn_level), (k >= 7) ? 32'h2 : 0);
            check("dis_valid", 32'(evt_valid), 0);
        end
        btn_raw = 3'b111;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            check("dis_rel_valid", 32'(evt_valid), 0);
        end
        enable = 1'b1;

        // Fill the FIFO with five presses while stalled; the fifth is dropped.
        evt_ready = 1'b0;
        d0 = drops;
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b000);
        btn_raw = 3'b110;
        tick(1);
        btn_raw = 3'b100;
        tick(1);
        btn_raw = 3'b000;
        tick(8);
        btn_raw = 3'b111;
        tick(14);
        check("fill_valid_3", 32'(evt_valid), 1);
        btn_raw = 3'b110;
        tick(1);
        btn_raw = 3'b100;
        tick(10);
        btn_raw = 3'b111;
        for (int k = 1; k <= 14; k++) begin
            tick(1);
            check("stall_code", 32'(evt_code), 0);
        end
        check("fill_valid_4", 32'(evt_valid), 1);
        check("fill_drops", 32'(drops - d0), 1);
        evt_ready = 1'b1;
        tick(6);
        check("drain_valid", 32'(evt_valid), 0);
        check("drain_sb_empty", 32'(exp_q.size()), 0);

        // Reset while button 0 is held with two queued events.
        evt_ready = 1'b0;
        btn_raw   = 3'b110;
        tick(17);
        check("prerst_valid", 32'(evt_valid), 1);
        check("prerst_level", 32'(btn_level), 1);
        rst = 1'b1;
        tick(1);
        check_idle_outputs("midrst");
        rst = 1'b0;
        exp_q.push_back(3'b000);
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            check($sformatf("rst_press_k%0d", k), 32'(btn_press), (k == 7) ? 1 : 0);
            check($sformatf("rst_valid_k%0d", k), 32'(evt_valid), (k == 8) ? 1 : 0);
        end
        evt_ready = 1'b1;
        tick(2);
        btn_raw = 3'b111;
        tick(16);
        check("final_valid", 32'(evt_valid), 0);
        check("final_level", 32'(btn_level), 0);
        check("final_sb_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
